prbs16_checker: RTL and testbench
=================================

# prbs16_checker

Receive-side counterpart of the team's 16-bit PRBS generator (x^16+x^15+x^13+x^4, XNOR feedback). It consumes one recovered serial bit per enabled cycle and self-synchronises a local copy of the generator from the incoming data. Once locked, it counts bit errors against the free-running local sequence and drops lock on excessive errors. It sits at the RX datapath output as a BER and link-integrity monitor.

## Interface
- LOCK_CNT, 32: consecutive correct predictions required to declare lock (1..65535).
- WINDOW, 128: valid-bit window length for loss-of-lock evaluation (2..65535).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 32: width of err_cnt and bit_cnt.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  din valid this cycle; no state advances when low.
- din  in  1  received serial bit.
- clr_cnt  in  1  zero err_cnt and bit_cnt; lock state unaffected.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle strobe: the bit accepted last cycle mismatched while locked.
- err_cnt  out  CNT_W  saturating error count while locked.
- bit_cnt  out  CNT_W  saturating count of bits checked while locked.

## Operation
- Stream definition: the generator's serial bit is the feedback bit shifted into LSB, nxt = s[15] XNOR s[14] XNOR s[12] XNOR s[3], then s <= {s[14:0], nxt}. The checker holds a 16-bit register s and a predicted bit p computed by the same function.
- States: SEARCH (reset state) and LOCKED.
- SEARCH, on each en: s <= {s[14:0], din}. fill counter increments, saturating at 16. Once fill = 16, compare din with p. On a match, match_cnt++. On a mismatch, match_cnt <= 0. When match_cnt reaches LOCK_CNT, go to LOCKED and clear the window counters.
- Lockup guard: if s = 16'hFFFF (the XNOR all-ones lockup state, i.e. stuck-high line), the cycle counts as a mismatch. The checker never locks on it.
- LOCKED, on each en: s <= {s[14:0], p}. The register free-runs and ignores din, so one flipped bit yields exactly one error.
  - bit_cnt++ on every en.
  - A mismatch (din != p) increments err_cnt, increments win_err, and asserts err_pulse on the next cycle.
  - win_bits++ on every en. At WINDOW, both win_bits and win_err return to 0.
  - If win_err reaches LOSS_THRESH, go to SEARCH on that bit. Entering SEARCH clears fill and match_cnt.
- err_cnt and bit_cnt hold at all-ones (no wrap). They retain their values across loss of lock and re-lock.
- If clr_cnt and an increment occur in the same cycle, clr_cnt wins: the counter becomes 0 and err_pulse still fires.
- en low: all state, counters and outputs hold, except err_pulse, which goes to 0.

## Timing
- All outputs are registered.
- Reset values: locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0. Internal reset values: s = 0, fill = 0, match_cnt = 0, window counters = 0, state SEARCH.
- Lock latency from a clean stream: 16 fill bits + LOCK_CNT matching bits. locked is high in the cycle after the accepted bit that completes the count (default 48 valid bits).
- err_pulse: one cycle, high in the cycle after the erroneous valid bit. err_cnt updates in the same cycle.
- Loss of lock: locked falls in the cycle after the bit that brings win_err to LOSS_THRESH. That bit is still counted in err_cnt.
- rst mid-operation takes effect on the next edge and overrides en and clr_cnt.

## Structure
- Shared package: the polynomial tap constant (bits 15, 14, 12, 3), the lockup constant 16'hFFFF, the state enum {SEARCH, LOCKED}, and a prbs16_next(s) function. The generator and checker both use this package.
- One sub-module: sat_counter (parameterised width, inc, clr), instantiated for err_cnt and bit_cnt. The FSM, LFSR and window logic stay in the top module.

## Test plan
- Clean stream: generator seeded with 16'hACE1, en held high, defaults. Required: locked = 1 after exactly 48 bits; 10 000 further bits give err_cnt = 0 and bit_cnt = 10 000.
- Single flip: while locked, invert one bit. Required: one err_pulse, err_cnt = 1, locked stays 1, and no follow-on errors.
- Burst: while locked, invert 8 bits within 128 valid bits. Required: locked falls after the 8th error, err_cnt = 8, and re-lock occurs 48 bits after the burst ends.
- Stuck line: din = 1 for 500 bits, then din = 0 for 500 bits. Required: locked stays 0 throughout and err_cnt = 0.
- en gaps: clean stream with en randomly low 50% of the time. Required: lock after 48 valid bits and bit_cnt equal to the number of valid bits.
- Counters and reset: assert clr_cnt in the same cycle as an error. Required: err_cnt = 0 and err_pulse = 1. Then assert rst while locked. Required: all outputs 0 next cycle.

Source files
------------

// File: rtl/prbs16_pkg.sv
// prbs16_pkg
// Shared definitions for the 16-bit PRBS generator and checker.
// Polynomial x^16+x^15+x^13+x^4 with XNOR feedback. The feedback bit is shifted
// into the LSB and is also the serial output bit.
//   PRBS16_TAPS   : register bits that feed the XNOR (15, 14, 12, 3)
//   PRBS16_LOCKUP : the XNOR lockup state; a register stuck here never leaves it
//   state_e       : checker FSM states
//   prbs16_next() : feedback / serial bit for a given register value
package prbs16_pkg;

    localparam logic [15:0] PRBS16_TAPS   = 16'hD008;
    localparam logic [15:0] PRBS16_LOCKUP = 16'hFFFF;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic prbs16_next(input logic [15:0] s);
        return ~(^(s & PRBS16_TAPS));
    endfunction

endpackage

// File: rtl/prbs16_if.sv
// prbs16_if
// Bundle between an RX datapath (master) and the PRBS checker (slave).
//   en        : din valid this cycle
//   din       : recovered serial bit
//   clr_cnt   : zero the error and bit counters
//   locked    : checker is locked to the incoming sequence
//   err_pulse : one-cycle strobe for an error seen while locked
//   err_cnt   : saturating error count
//   bit_cnt   : saturating count of bits checked while locked
interface prbs16_if #(
    parameter int CNT_W = 32
) ();

    logic             en;
    logic             din;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output en, din, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );

    modport slave (
        input  en, din, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );

endinterface

// File: rtl/prbs16_checker_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one (ignored once saturated)
//   clr      : force to zero; wins over inc
//   cnt      : registered count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prbs16_checker.sv
// prbs16_checker
// Self-synchronising receive checker for the 16-bit XNOR PRBS generator.
// In SEARCH the register is loaded from din; after 16 fill bits each bit is
// compared against the prediction, and LOCK_CNT consecutive matches lock it.
// In LOCKED the register free-runs on its own prediction, so a single flipped
// bit costs exactly one error. LOSS_THRESH errors inside one WINDOW of valid
// bits drop back to SEARCH.
//   clk, rst : clock, synchronous active-high reset
//   bus      : prbs16_if slave (en, din, clr_cnt in; locked, err_pulse,
//              err_cnt, bit_cnt out)
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_CNT    = 32,
    parameter int WINDOW      = 128,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic    clk,
    input  logic    rst,
    prbs16_if.slave bus
);

    state_e      state_q, state_d;
    logic [15:0] s_q, s_d;
    logic [4:0]  fill_q, fill_d;
    logic [15:0] match_cnt_q, match_cnt_d;
    logic [15:0] win_bits_q, win_bits_d;
    logic [15:0] win_err_q, win_err_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;

    logic        p;
    logic        err_inc;
    logic        bit_inc;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    assign p = prbs16_next(s_q);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;

        if (bus.en) begin
            case (state_q)
                SEARCH: begin
                    s_d = {s_q[14:0], bus.din};
                    if (fill_q != 5'd16) begin
                        fill_d = fill_q + 5'd1;
                    end else if ((bus.din == p) && (s_q != PRBS16_LOCKUP)) begin
                        // A stuck-high line sits in the lockup state and
                        // predicts itself; it is treated as a mismatch above.
                        if (int'(match_cnt_q) + 1 >= LOCK_CNT) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            win_bits_d  = '0;
                            win_err_d   = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 16'd1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    s_d         = {s_q[14:0], p};
                    bit_inc     = 1'b1;
                    err_inc     = (bus.din != p);
                    err_pulse_d = err_inc;
                    // Loss is judged on the updated error count, before any
                    // window wrap on the same bit.
                    if (err_inc && (int'(win_err_q) + 1 >= LOSS_THRESH)) begin
                        state_d     = SEARCH;
                        fill_d      = '0;
                        match_cnt_d = '0;
                        win_bits_d  = '0;
                        win_err_d   = '0;
                    end else if (int'(win_bits_q) + 1 >= WINDOW) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        win_bits_d = win_bits_q + 16'd1;
                        win_err_d  = win_err_q + 16'(err_inc);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            s_q         <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (bus.clr_cnt),
        .cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bit_inc),
        .clr (bus.clr_cnt),
        .cnt (bit_cnt)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt;
    assign bus.bit_cnt   = bit_cnt;

endmodule

// File: tb/tb_prbs16_checker.sv
// tb_prbs16_checker
// Drives PRBS16 streams (with flips, bursts, stuck levels and valid gaps) into
// prbs16_checker and checks lock timing, error strobes and counters against
// expectations derived from the stream the bench itself generates.
module tb_prbs16_checker;

    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] g;
    int          n_cmp = 0;
    int          n_err = 0;

    prbs16_if #(.CNT_W(CNT_W)) bus ();

    prbs16_checker #(
        .LOCK_CNT    (32),
        .WINDOW      (128),
        .LOSS_THRESH (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference generator: serial bit is the XNOR of taps 15,14,12,3.
    task automatic gen(output logic b);
        b = ~(g[15] ^ g[14] ^ g[12] ^ g[3]);
        g = {g[14:0], b};
    endtask

    task automatic cycle(input logic e, input logic d, input logic c);
        bus.en      = e;
        bus.din     = d;
        bus.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic seed_gen();
        g = 16'($urandom_range(0, 16'hFFFE));
    endtask

    // Feed clean bits until locked; n = bits fed, or -1 if the bound expired.
    task automatic lock_up(output int n);
        logic b;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            gen(b);
            cycle(1'b1, b, 1'b0);
            n++;
            if (bus.locked) break;
        end
        if (!bus.locked) n = -1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.din = 1'b0; bus.clr_cnt = 1'b0;
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_err++; $display("FAIL reset_err_pulse got=%b want=0", bus.err_pulse); end
        n_cmp++; if (bus.err_cnt !== '0) begin n_err++; $display("FAIL reset_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.bit_cnt !== '0) begin n_err++; $display("FAIL reset_bit_cnt got=%0d want=0", bus.bit_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_clean_stream();
        int   n;
        int   pulses;
        logic b;
        do_reset();
        g = 16'hACE1;
        lock_up(n);
        n_cmp++; if (n !== 48) begin n_err++; $display("FAIL clean_lock_bits got=%0d want=48", n); end
        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            gen(b);
            cycle(1'b1, b, 1'b0);
            if (bus.err_pulse) pulses++;
        end
        n_cmp++; if (bus.err_cnt !== 32'd0) begin n_err++; $display("FAIL clean_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.bit_cnt !== 32'd10000) begin n_err++; $display("FAIL clean_bit_cnt got=%0d want=10000", bus.bit_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL clean_locked got=%b want=1", bus.locked); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL clean_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_single_flip();
        int   n, k, pulses, pulse_at;
        logic b;
        do_reset();
        seed_gen();
        lock_up(n);
        n_cmp++; if (n !== 48) begin n_err++; $display("FAIL flip_lock_bits got=%0d want=48", n); end
        k = $urandom_range(20, 200);
        pulses = 0;
        pulse_at = -1;
        for (int i = 1; i <= 300; i++) begin
            gen(b);
            cycle(1'b1, b ^ (i == k), 1'b0);
            if (bus.err_pulse) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL flip_pulses got=%0d want=1", pulses); end
        n_cmp++; if (pulse_at !== k) begin n_err++; $display("FAIL flip_pulse_pos got=%0d want=%0d", pulse_at, k); end
        n_cmp++; if (bus.err_cnt !== 32'd1) begin n_err++; $display("FAIL flip_err_cnt got=%0d want=1", bus.err_cnt); end
        n_cmp++; if (bus.bit_cnt !== 32'd300) begin n_err++; $display("FAIL flip_bit_cnt got=%0d want=300", bus.bit_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL flip_locked got=%b want=1", bus.locked); end
    endtask

    task automatic test_burst();
        int   n, pos, last, fi;
        int   fp [8];
        logic b, flip, lock_before_last, early_drop;
        do_reset();
        seed_gen();
        lock_up(n);
        n_cmp++; if (n !== 48) begin n_err++; $display("FAIL burst_lock_bits got=%0d want=48", n); end
        // Eight flips spread over at most 106 bits, all inside the first window.
        pos = $urandom_range(0, 50);
        for (int j = 0; j < 8; j++) begin
            pos += $urandom_range(1, 7);
            fp[j] = pos;
        end
        last = fp[7];
        fi = 0;
        lock_before_last = 1'b0;
        early_drop = 1'b0;
        for (int i = 1; i <= last; i++) begin
            gen(b);
            flip = 1'b0;
            if (fi < 8 && i == fp[fi]) begin
                flip = 1'b1;
                fi++;
            end
            if (i == last) lock_before_last = bus.locked;
            cycle(1'b1, b ^ flip, 1'b0);
            if (i < last && !bus.locked) early_drop = 1'b1;
        end
        n_cmp++; if (early_drop !== 1'b0) begin n_err++; $display("FAIL burst_early_drop got=%b want=0", early_drop); end
        n_cmp++; if (lock_before_last !== 1'b1) begin n_err++; $display("FAIL burst_lock_before_8th got=%b want=1", lock_before_last); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL burst_locked_after_8th got=%b want=0", bus.locked); end
        n_cmp++; if (bus.err_cnt !== 32'd8) begin n_err++; $display("FAIL burst_err_cnt got=%0d want=8", bus.err_cnt); end
        n_cmp++; if (bus.bit_cnt !== 32'(last)) begin n_err++; $display("FAIL burst_bit_cnt got=%0d want=%0d", bus.bit_cnt, last); end
        lock_up(n);
        n_cmp++; if (n !== 48) begin n_err++; $display("FAIL burst_relock_bits got=%0d want=48", n); end
        n_cmp++; if (bus.err_cnt !== 32'd8) begin n_err++; $display("FAIL burst_err_cnt_retained got=%0d want=8", bus.err_cnt); end
    endtask

    task automatic test_stuck_line();
        logic seen_lock;
        int   pulses;
        do_reset();
        seen_lock = 1'b0;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, (i < 500), 1'b0);
            if (bus.locked) seen_lock = 1'b1;
            if (bus.err_pulse) pulses++;
        end
        n_cmp++; if (seen_lock !== 1'b0) begin n_err++; $display("FAIL stuck_locked got=%b want=0", seen_lock); end
        n_cmp++; if (bus.err_cnt !== 32'd0) begin n_err++; $display("FAIL stuck_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL stuck_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_en_gaps();
        int   n, valid, pulses;
        logic b, lost;
        do_reset();
        seed_gen();
        n = 0;
        for (int c = 0; c < 2000 && !bus.locked; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen(b);
                cycle(1'b1, b, 1'b0);
                n++;
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        n_cmp++; if (n !== 48 || !bus.locked) begin n_err++; $display("FAIL gaps_lock_bits got=%0d locked=%b want=48", n, bus.locked); end
        valid = 0;
        pulses = 0;
        lost = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen(b);
                cycle(1'b1, b, 1'b0);
                valid++;
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (bus.err_pulse) pulses++;
            if (!bus.locked) lost = 1'b1;
        end
        n_cmp++; if (bus.bit_cnt !== 32'(valid)) begin n_err++; $display("FAIL gaps_bit_cnt got=%0d want=%0d", bus.bit_cnt, valid); end
        n_cmp++; if (bus.err_cnt !== 32'd0) begin n_err++; $display("FAIL gaps_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (lost !== 1'b0) begin n_err++; $display("FAIL gaps_lock_held got=%b want=0", lost); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL gaps_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_clr_and_reset();
        int   n;
        logic b;
        do_reset();
        seed_gen();
        lock_up(n);
        n_cmp++; if (n !== 48) begin n_err++; $display("FAIL clr_lock_bits got=%0d want=48", n); end
        for (int i = 0; i < 20; i++) begin
            gen(b);
            cycle(1'b1, b, 1'b0);
        end
        gen(b);
        cycle(1'b1, ~b, 1'b1);
        n_cmp++; if (bus.err_cnt !== 32'd0) begin n_err++; $display("FAIL clr_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.err_pulse !== 1'b1) begin n_err++; $display("FAIL clr_err_pulse got=%b want=1", bus.err_pulse); end
        n_cmp++; if (bus.bit_cnt !== 32'd0) begin n_err++; $display("FAIL clr_bit_cnt got=%0d want=0", bus.bit_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL clr_locked got=%b want=1", bus.locked); end
        gen(b);
        cycle(1'b1, b, 1'b0);
        n_cmp++; if (bus.bit_cnt !== 32'd1) begin n_err++; $display("FAIL clr_bit_cnt_resume got=%0d want=1", bus.bit_cnt); end
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_err++; $display("FAIL clr_pulse_one_cycle got=%b want=0", bus.err_pulse); end
        // Reset coincides with an erroneous bit and clr_cnt low: reset must win.
        gen(b);
        rst = 1'b1;
        cycle(1'b1, ~b, 1'b0);
        rst = 1'b0;
        n_cmp++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL rst_locked got=%b want=0", bus.locked); end
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_err++; $display("FAIL rst_err_pulse got=%b want=0", bus.err_pulse); end
        n_cmp++; if (bus.err_cnt !== 32'd0) begin n_err++; $display("FAIL rst_err_cnt got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.bit_cnt !== 32'd0) begin n_err++; $display("FAIL rst_bit_cnt got=%0d want=0", bus.bit_cnt); end
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.din     = 1'b0;
        bus.clr_cnt = 1'b0;
        g           = 16'h0000;
        test_reset();
        test_clean_stream();
        test_single_flip();
        test_burst();
        test_stuck_line();
        test_en_gaps();
        test_clr_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
